quadrature_counter: RTL and testbench

QUADRATURE_COUNTER -- requirements
Module: quadrature_counter

---
 rtl/quadrature_counter_pkg.sv | 29 ++
 rtl/quad_defs.vh | 13 +
 rtl/quad_input_filter.sv | 47 ++++
 rtl/quadrature_counter.sv | 83 ++++++++
 tb/tb_quadrature_counter.sv | 139 +++++++++++++
 5 files changed

// File: rtl/quadrature_counter_pkg.sv
// Step codes and the {a,b} transition decoder shared by the counter.
package quadrature_counter_pkg;

    `include "quad_defs.vh"

    typedef logic [1:0] step_t;

    // Position of an {a,b} state within the forward sequence (0..3)
    function automatic logic [1:0] quad_pos(input logic [1:0] ab);
        logic [1:0] p;
        p = 2'd0;
        for (int i = 0; i < 4; i++)
            if (QUAD_SEQ[7-2*i -: 2] == ab) p = 2'(i);
        return p;
    endfunction

    // Classify a filtered transition by its distance along the sequence
    function automatic step_t step_decode(input logic [1:0] prev, input logic [1:0] cur);
        logic [1:0] d;
        d = quad_pos(cur) - quad_pos(prev);
        case (d)
            2'd0:    return STEP_NONE;
            2'd1:    return STEP_UP;
            2'd3:    return STEP_DOWN;
            default: return STEP_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/quad_defs.vh
// Shared quadrature step codes and the forward {a,b} sequence.
`ifndef QUAD_DEFS_VH
`define QUAD_DEFS_VH

localparam logic [1:0] STEP_NONE    = 2'd0;
localparam logic [1:0] STEP_UP      = 2'd1;
localparam logic [1:0] STEP_DOWN    = 2'd2;
localparam logic [1:0] STEP_ILLEGAL = 2'd3;

// Forward order, position 0 in the top slice: 00 -> 01 -> 11 -> 10 -> 00
localparam logic [7:0] QUAD_SEQ = {2'b00, 2'b01, 2'b11, 2'b10};

`endif

// File: rtl/quad_input_filter.sv
// Two-flop synchroniser plus stability filter for a W-bit group of raw inputs.
module quad_input_filter #(
    parameter int W          = 1,
    parameter int FILTER_LEN = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] s1, s2, cand, filt;
    logic [3:0]   cnt;
    logic [4:0]   nxt;

    // Length of the current run of an unchanged, not-yet-accepted value
    always_comb begin
        nxt = 5'd1;
        if (s2 == cand && cnt != 4'd0) nxt = {1'b0, cnt} + 5'd1;
    end

    // Synchronise, then accept a new value once it has held FILTER_LEN clocks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= '0;
            s2   <= '0;
            cand <= '0;
            filt <= '0;
            cnt  <= '0;
        end else begin
            s1   <= din;
            s2   <= s1;
            cand <= s2;
            if (s2 == filt) begin
                cnt <= '0;
            end else if (nxt >= 5'(FILTER_LEN)) begin
                filt <= s2;
                cnt  <= '0;
            end else begin
                cnt <= nxt[3:0];
            end
        end
    end

    assign dout = filt;

endmodule

// File: rtl/quadrature_counter.sv
// Quadrature encoder position counter with index capture and error tracking.
module quadrature_counter
    import quadrature_counter_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int FILTER_LEN = 2,
    parameter int SATURATE   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             idx,
    input  logic             idx_zero_en,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] idx_pos,
    output logic             dir,
    output logic             step,
    output logic             err,
    output logic [7:0]       err_cnt
);

    localparam logic [WIDTH-1:0] CMAX = {WIDTH{1'b1}};

    logic [1:0] ab_f, ab_prev;
    logic       idx_f, idx_prev;
    logic       idx_rise;
    step_t      sc;

    // a and b share one filter so both phases are accepted together
    quad_input_filter #(.W(2), .FILTER_LEN(FILTER_LEN)) u_ab_filt (
        .clk(clk), .rst_n(rst_n), .din({a, b}), .dout(ab_f)
    );

    quad_input_filter #(.W(1), .FILTER_LEN(FILTER_LEN)) u_idx_filt (
        .clk(clk), .rst_n(rst_n), .din(idx), .dout(idx_f)
    );

    assign sc       = step_decode(ab_prev, ab_f);
    assign idx_rise = idx_f & ~idx_prev;

    // Apply filtered steps with priority clr > index zeroing > step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ab_prev  <= 2'b00;
            idx_prev <= 1'b0;
            count    <= '0;
            idx_pos  <= '0;
            dir      <= 1'b0;
            step     <= 1'b0;
            err      <= 1'b0;
            err_cnt  <= '0;
        end else begin
            ab_prev  <= ab_f;
            idx_prev <= idx_f;
            step     <= 1'b0;
            if (idx_rise) idx_pos <= count;
            if (sc == STEP_UP)   dir <= 1'b1;
            if (sc == STEP_DOWN) dir <= 1'b0;
            if (clr) begin
                count   <= '0;
                err     <= 1'b0;
                err_cnt <= '0;
            end else begin
                if (sc == STEP_ILLEGAL) begin
                    err <= 1'b1;
                    if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                end
                if (idx_rise && idx_zero_en) begin
                    count <= '0;
                end else if (sc == STEP_UP) begin
                    step <= 1'b1;
                    if (!(SATURATE != 0 && count == CMAX)) count <= count + WIDTH'(1);
                end else if (sc == STEP_DOWN) begin
                    step <= 1'b1;
                    if (!(SATURATE != 0 && count == '0)) count <= count - WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_quadrature_counter.sv
// Directed bench: wrapping (u0) and saturating (u1) counters driven in parallel.
module tb_quadrature_counter;

    logic       clk = 1'b0;
    logic       rst_n, a, b, idx, idx_zero_en, clr;
    logic [7:0] count0, idx_pos0, err_cnt0, count1, idx_pos1, err_cnt1;
    logic       dir0, step0, err0, dir1, step1, err1;
    int         n_chk = 0, n_pass = 0;
    logic       saw_step0 = 1'b0;

    always #5 clk = ~clk;

    quadrature_counter #(.WIDTH(8), .FILTER_LEN(2), .SATURATE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .idx(idx), .idx_zero_en(idx_zero_en),
        .clr(clr), .count(count0), .idx_pos(idx_pos0), .dir(dir0), .step(step0),
        .err(err0), .err_cnt(err_cnt0)
    );

    quadrature_counter #(.WIDTH(8), .FILTER_LEN(2), .SATURATE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .idx(idx), .idx_zero_en(idx_zero_en),
        .clr(clr), .count(count1), .idx_pos(idx_pos1), .dir(dir1), .step(step1),
        .err(err1), .err_cnt(err_cnt1)
    );

    always @(negedge clk) if (step0) saw_step0 = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic move(input logic [1:0] v);
        {a, b} = v;
        repeat (8) tick();
    endtask

    initial begin
        rst_n = 1'b0; a = 0; b = 0; idx = 0; idx_zero_en = 0; clr = 0;
        repeat (2) tick();
        chk("rst_count", count0, 0);
        chk("rst_idx_pos", idx_pos0, 0);
        chk("rst_err", {err0, err_cnt0}, 0);
        chk("rst_step_dir", {step0, dir0}, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // latency: 00 -> 01, count moves on the 5th edge
        {a, b} = 2'b01;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("lat_count_%0d", k), count0, (k == 5) ? 1 : 0);
            if (k >= 4) chk($sformatf("lat_step_%0d", k), step0, (k == 5) ? 1 : 0);
        end
        repeat (3) tick();
        chk("step_one_clock", step0, 0);
        chk("dir_up", dir0, 1);

        // forward then back and forth
        move(2'b11); chk("seq_11", {count0, 7'd0, dir0}, {8'd2, 7'd0, 1'b1});
        move(2'b10); chk("seq_10", {count0, 7'd0, dir0}, {8'd3, 7'd0, 1'b1});
        move(2'b00); chk("seq_00", {count0, 7'd0, dir0}, {8'd4, 7'd0, 1'b1});
        move(2'b10); chk("seq_rev", {count0, 7'd0, dir0}, {8'd3, 7'd0, 1'b0});
        move(2'b00); chk("seq_fwd", {count0, 7'd0, dir0}, {8'd4, 7'd0, 1'b1});

        // glitches shorter than the window, each change restarting it
        saw_step0 = 1'b0;
        a = 1; tick(); a = 0; repeat (3) tick();
        a = 1; tick(); a = 0; tick(); a = 1; tick(); a = 0;
        repeat (8) tick();
        chk("glitch_count", count0, 4);
        chk("glitch_no_step", saw_step0, 0);

        // illegal jump, then clear
        move(2'b11);
        chk("ill_count", count0, 4);
        chk("ill_err", err0, 1);
        chk("ill_err_cnt", err_cnt0, 1);
        clr = 1; tick(); clr = 0;
        chk("clr_err", err0, 0);
        chk("clr_err_cnt", err_cnt0, 0);
        chk("clr_count", count0, 0);
        chk("clr_count_sat", count1, 0);

        // reverse step from 0: wrap vs clamp
        move(2'b01);
        chk("wrap_down", count0, 255);
        chk("clamp_down", count1, 0);
        chk("clamp_dir", dir1, 0);
        move(2'b11);
        chk("wrap_up", count0, 0);
        move(2'b10); move(2'b00); move(2'b01); move(2'b11); move(2'b10); move(2'b00); move(2'b01);
        chk("pre_idx_count", count0, 7);
        chk("pre_idx_count_sat", count1, 8);

        // index zeroing coinciding with a forward step
        saw_step0 = 1'b0;
        idx_zero_en = 1; idx = 1; {a, b} = 2'b11;
        repeat (8) tick();
        idx = 0; idx_zero_en = 0;
        chk("idx_pos", idx_pos0, 7);
        chk("idx_pos_sat", idx_pos1, 8);
        chk("idx_zero", count0, 0);
        chk("idx_dir", dir0, 1);
        chk("idx_step_dropped", saw_step0, 0);
        repeat (8) tick();

        // reset asserted mid-filter
        {a, b} = 2'b10;
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_count", count0, 0);
        chk("mid_rst_idx_pos", idx_pos0, 0);
        chk("mid_rst_misc", {step0, dir0, err0, err_cnt0}, 0);
        {a, b} = 2'b00;
        #10 rst_n = 1'b1;
        saw_step0 = 1'b0;
        repeat (8) tick();
        chk("discard_count", count0, 0);
        chk("discard_step", saw_step0, 0);

        // 11 present out of reset is an illegal jump from 00
        rst_n = 1'b0; {a, b} = 2'b11;
        #7 rst_n = 1'b1;
        repeat (8) tick();
        chk("rst11_err", {err0, err_cnt0}, {1'b1, 8'd1});
        chk("rst11_count", count0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
